// File: rtl/ysyx_25040129_pkg.sv
// Shared definitions for the ysyx_25040129 core's load/store path.
//   MEM_*        funct3 encodings of the RV32 load/store instructions
//   OKAY         AXI response code for a successful transfer
//   lsu_state_t  LSU sequencer states
//   mem_misaligned  true when a halfword/word access is not naturally aligned
package ysyx_25040129_pkg;

  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b100;
  localparam logic [2:0] MEM_LHU = 3'b101;
  localparam logic [2:0] MEM_SB  = 3'b000;
  localparam logic [2:0] MEM_SH  = 3'b001;
  localparam logic [2:0] MEM_SW  = 3'b010;

  localparam logic [1:0] OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } lsu_state_t;

  // size is funct3[1:0]: 00 byte, 01 halfword, 10 word
  function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25040129_lsu_align.sv
// Byte-lane steering for the LSU, purely combinational.
//   i_addr_lo  low two bits of the effective address
//   i_op       funct3 of the memory instruction
//   i_rdata    raw read-data word from the bus
//   i_sdata    rs2 value of a store
//   o_ldata    load result, shifted down and sign/zero extended
//   o_wdata    store data shifted onto its byte lanes
//   o_wstrb    byte enables for the store
module ysyx_25040129_lsu_align
  import ysyx_25040129_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_sdata,
  output logic [31:0] o_ldata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb
);

  logic [4:0]  w_shamt;
  logic [31:0] w_rshift;

  assign w_shamt  = {i_addr_lo, 3'b000};
  assign w_rshift = i_rdata >> w_shamt;
  assign o_wdata  = i_sdata << w_shamt;

  always_comb begin
    o_ldata = w_rshift;
    case (i_op)
      MEM_LB:  o_ldata = {{24{w_rshift[7]}}, w_rshift[7:0]};
      MEM_LH:  o_ldata = {{16{w_rshift[15]}}, w_rshift[15:0]};
      MEM_LBU: o_ldata = {24'h0, w_rshift[7:0]};
      MEM_LHU: o_ldata = {16'h0, w_rshift[15:0]};
      default: o_ldata = w_rshift;
    endcase
  end

  always_comb begin
    o_wstrb = 4'b1111;
    case (i_op[1:0])
      2'b00:   o_wstrb = 4'b0001 << i_addr_lo;
      2'b01:   o_wstrb = 4'b0011 << i_addr_lo;
      default: o_wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ysyx_25040129_lsu.sv
// Load/store unit between EXU and WBU of the multi-cycle RV32E core.
// Takes one instruction at a time from EXU, runs at most one AXI4-Lite
// read or write for it, and parks the result in a one-entry output
// register until WBU accepts it.
//   clock/reset          core clock, async active-low reset
//   *_from_exu/_to_exu   EXU valid/ready and instruction fields (*_in_lsu)
//   *_to_wbu/_from_wbu   WBU valid/ready and registered fields (*_out_lsu)
//   ar*/r*               read address / read data channels
//   aw*/w*/b*            write address / write data / write response channels
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | waiting for EXU; non-memory ops complete from here
// RD_ADDR | arvalid high, waiting for arready
// RD_DATA | waiting for rvalid; rready only while output reg free
// WR_REQ  | awvalid/wvalid high until each is accepted
// WR_RESP | waiting for bvalid; bready only while output reg free
module ysyx_25040129_lsu
  import ysyx_25040129_pkg::*;
#(
  parameter int REGS_DIG = 5,
  parameter int CSR_DIG  = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                is_req_valid_from_exu,
  output logic                is_req_ready_to_exu,
  input  logic [REGS_DIG-1:0] rd_in_lsu,
  input  logic [31:0]         result_in_lsu,
  input  logic [31:0]         store_data_in_lsu,
  input  logic [2:0]          mem_op_in_lsu,
  input  logic                is_load_in_lsu,
  input  logic                is_store_in_lsu,
  input  logic [CSR_DIG-1:0]  csr_addr_in_lsu,
  input  logic                csr_write_in_lsu,
  input  logic                reg_write_in_lsu,
  input  logic                ebreak_in_lsu,
  output logic                is_req_valid_to_wbu,
  input  logic                is_req_ready_from_wbu,
  output logic [REGS_DIG-1:0] rd_out_lsu,
  output logic [31:0]         result_out_lsu,
  output logic [CSR_DIG-1:0]  csr_addr_out_lsu,
  output logic                csr_write_out_lsu,
  output logic                reg_write_out_lsu,
  output logic                ebreak_out_lsu,
  output logic                access_fault_out_lsu,
  output logic [31:0]         araddr,
  output logic                arvalid,
  input  logic                arready,
  output logic [2:0]          arsize,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [31:0]         awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [2:0]          awsize,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  lsu_state_t r_state;

  logic [31:0]         r_addr;
  logic [31:0]         r_sdata;
  logic [2:0]          r_op;
  logic [REGS_DIG-1:0] r_rd;
  logic [CSR_DIG-1:0]  r_csr_addr;
  logic                r_csr_write;
  logic                r_reg_write;
  logic                r_ebreak;

  logic                r_arvalid;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_aw_done;
  logic                r_w_done;

  logic                r_out_valid;
  logic [REGS_DIG-1:0] r_out_rd;
  logic [31:0]         r_out_result;
  logic [CSR_DIG-1:0]  r_out_csr_addr;
  logic                r_out_csr_write;
  logic                r_out_reg_write;
  logic                r_out_ebreak;
  logic                r_out_fault;

  logic        w_out_free;
  logic        w_fire;
  logic        w_is_mem;
  logic        w_misalign;
  logic        w_aw_done_nx;
  logic        w_w_done_nx;
  logic        w_rd_fault;
  logic        w_wr_fault;
  logic [31:0] w_ldata;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;

  // The output register can take a new entry if it is empty or being drained this cycle.
  assign w_out_free          = !r_out_valid || is_req_ready_from_wbu;
  assign is_req_ready_to_exu = (r_state == IDLE) && w_out_free;
  assign w_fire              = is_req_valid_from_exu && is_req_ready_to_exu;
  assign w_is_mem            = is_load_in_lsu || is_store_in_lsu;
  assign w_misalign          = w_is_mem && mem_misaligned(mem_op_in_lsu[1:0], result_in_lsu[1:0]);
  assign w_aw_done_nx        = r_aw_done || (r_awvalid && awready);
  assign w_w_done_nx         = r_w_done || (r_wvalid && wready);
  assign w_rd_fault          = rresp != OKAY;
  assign w_wr_fault          = bresp != OKAY;

  ysyx_25040129_lsu_align u_align (
    .i_addr_lo (r_addr[1:0]),
    .i_op      (r_op),
    .i_rdata   (rdata),
    .i_sdata   (r_sdata),
    .o_ldata   (w_ldata),
    .o_wdata   (w_wdata),
    .o_wstrb   (w_wstrb)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_sdata         <= '0;
      r_op            <= '0;
      r_rd            <= '0;
      r_csr_addr      <= '0;
      r_csr_write     <= 1'b0;
      r_reg_write     <= 1'b0;
      r_ebreak        <= 1'b0;
      r_arvalid       <= 1'b0;
      r_awvalid       <= 1'b0;
      r_wvalid        <= 1'b0;
      r_aw_done       <= 1'b0;
      r_w_done        <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_rd        <= '0;
      r_out_result    <= '0;
      r_out_csr_addr  <= '0;
      r_out_csr_write <= 1'b0;
      r_out_reg_write <= 1'b0;
      r_out_ebreak    <= 1'b0;
      r_out_fault     <= 1'b0;
    end else begin
      // WBU draining; any completion below overrides this with a new entry.
      if (r_out_valid && is_req_ready_from_wbu) r_out_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_fire) begin
            r_addr      <= result_in_lsu;
            r_sdata     <= store_data_in_lsu;
            r_op        <= mem_op_in_lsu;
            r_rd        <= rd_in_lsu;
            r_csr_addr  <= csr_addr_in_lsu;
            r_csr_write <= csr_write_in_lsu;
            r_reg_write <= reg_write_in_lsu;
            r_ebreak    <= ebreak_in_lsu;
            if (w_is_mem && !w_misalign) begin
              if (is_load_in_lsu) begin
                r_state   <= RD_ADDR;
                r_arvalid <= 1'b1;
              end else begin
                r_state   <= WR_REQ;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
              end
            end else begin
              // Passthrough, or a misaligned access that never reaches the bus.
              r_out_valid     <= 1'b1;
              r_out_rd        <= rd_in_lsu;
              r_out_result    <= result_in_lsu;
              r_out_csr_addr  <= csr_addr_in_lsu;
              r_out_csr_write <= csr_write_in_lsu && !w_misalign;
              r_out_reg_write <= reg_write_in_lsu && !w_misalign;
              r_out_ebreak    <= ebreak_in_lsu;
              r_out_fault     <= w_misalign;
            end
          end
        end

        RD_ADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_state   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (rvalid && w_out_free) begin
            r_state         <= IDLE;
            r_out_valid     <= 1'b1;
            r_out_rd        <= r_rd;
            r_out_result    <= w_ldata;
            r_out_csr_addr  <= r_csr_addr;
            r_out_csr_write <= r_csr_write && !w_rd_fault;
            r_out_reg_write <= r_reg_write && !w_rd_fault;
            r_out_ebreak    <= r_ebreak;
            r_out_fault     <= w_rd_fault;
          end
        end

        WR_REQ: begin
          if (r_awvalid && awready) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && wready) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_done_nx && w_w_done_nx) r_state <= WR_RESP;
        end

        WR_RESP: begin
          if (bvalid && w_out_free) begin
            r_state         <= IDLE;
            r_out_valid     <= 1'b1;
            r_out_rd        <= r_rd;
            r_out_result    <= r_addr;
            r_out_csr_addr  <= r_csr_addr;
            r_out_csr_write <= r_csr_write && !w_wr_fault;
            r_out_reg_write <= r_reg_write && !w_wr_fault;
            r_out_ebreak    <= r_ebreak;
            r_out_fault     <= w_wr_fault;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  // Response-side readies are decoded so they fall the same cycle the output register fills.
  assign rready  = (r_state == RD_DATA) && w_out_free;
  assign bready  = (r_state == WR_RESP) && w_out_free;

  assign araddr  = r_addr;
  assign arvalid = r_arvalid;
  assign arsize  = {1'b0, r_op[1:0]};
  assign awaddr  = r_addr;
  assign awvalid = r_awvalid;
  assign awsize  = {1'b0, r_op[1:0]};
  assign wvalid  = r_wvalid;
  assign wdata   = w_wdata;
  assign wstrb   = r_wvalid ? w_wstrb : 4'b0000;

  assign is_req_valid_to_wbu  = r_out_valid;
  assign rd_out_lsu           = r_out_rd;
  assign result_out_lsu       = r_out_result;
  assign csr_addr_out_lsu     = r_out_csr_addr;
  assign csr_write_out_lsu    = r_out_csr_write;
  assign reg_write_out_lsu    = r_out_reg_write;
  assign ebreak_out_lsu       = r_out_ebreak;
  assign access_fault_out_lsu = r_out_fault;

endmodule

// File: tb/tb_ysyx_25040129_lsu.sv
// Directed bench for ysyx_25040129_lsu. The bench plays EXU, WBU and a
// scripted bus slave; inputs change on the falling edge, outputs are
// sampled on the falling edge.
module tb_ysyx_25040129_lsu;
  import ysyx_25040129_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        is_req_valid_from_exu, is_req_ready_to_exu;
  logic [4:0]  rd_in_lsu, rd_out_lsu;
  logic [31:0] result_in_lsu, store_data_in_lsu, result_out_lsu;
  logic [2:0]  mem_op_in_lsu;
  logic        is_load_in_lsu, is_store_in_lsu;
  logic [11:0] csr_addr_in_lsu, csr_addr_out_lsu;
  logic        csr_write_in_lsu, reg_write_in_lsu, ebreak_in_lsu;
  logic        is_req_valid_to_wbu, is_req_ready_from_wbu;
  logic        csr_write_out_lsu, reg_write_out_lsu, ebreak_out_lsu, access_fault_out_lsu;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [2:0]  arsize, awsize;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  ysyx_25040129_lsu #(.REGS_DIG(5), .CSR_DIG(12)) dut (
    .clock(clock), .reset(reset),
    .is_req_valid_from_exu(is_req_valid_from_exu), .is_req_ready_to_exu(is_req_ready_to_exu),
    .rd_in_lsu(rd_in_lsu), .result_in_lsu(result_in_lsu), .store_data_in_lsu(store_data_in_lsu),
    .mem_op_in_lsu(mem_op_in_lsu), .is_load_in_lsu(is_load_in_lsu), .is_store_in_lsu(is_store_in_lsu),
    .csr_addr_in_lsu(csr_addr_in_lsu), .csr_write_in_lsu(csr_write_in_lsu),
    .reg_write_in_lsu(reg_write_in_lsu), .ebreak_in_lsu(ebreak_in_lsu),
    .is_req_valid_to_wbu(is_req_valid_to_wbu), .is_req_ready_from_wbu(is_req_ready_from_wbu),
    .rd_out_lsu(rd_out_lsu), .result_out_lsu(result_out_lsu), .csr_addr_out_lsu(csr_addr_out_lsu),
    .csr_write_out_lsu(csr_write_out_lsu), .reg_write_out_lsu(reg_write_out_lsu),
    .ebreak_out_lsu(ebreak_out_lsu), .access_fault_out_lsu(access_fault_out_lsu),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arsize(arsize),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awsize(awsize),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic req(input logic ld, input logic st, input logic [2:0] op,
                     input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rd,
                     input logic rw, input logic cw, input logic [11:0] ca, input logic eb);
    is_req_valid_from_exu = 1'b1;
    is_load_in_lsu        = ld;
    is_store_in_lsu       = st;
    mem_op_in_lsu         = op;
    result_in_lsu         = res;
    store_data_in_lsu     = sd;
    rd_in_lsu             = rd;
    reg_write_in_lsu      = rw;
    csr_write_in_lsu      = cw;
    csr_addr_in_lsu       = ca;
    ebreak_in_lsu         = eb;
  endtask

  task automatic req_off();
    is_req_valid_from_exu = 1'b0;
    is_load_in_lsu        = 1'b0;
    is_store_in_lsu       = 1'b0;
  endtask

  // Load against a zero-wait slave: fire, AR handshake, R handshake.
  task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rdat,
                         input logic [1:0] resp, input logic [4:0] rd);
    req(1'b1, 1'b0, op, addr, 32'h0, rd, 1'b1, 1'b0, 12'h0, 1'b0);
    @(negedge clock);
    req_off();
    check("ar_valid", 32'(arvalid), 32'd1);
    check("ar_addr", araddr, addr);
    check("ar_size", 32'(arsize), 32'(op[1:0]));
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0;
    check("ar_drop", 32'(arvalid), 32'd0);
    check("r_ready", 32'(rready), 32'd1);
    check("ld_not_early", 32'(is_req_valid_to_wbu), 32'd0);
    rvalid = 1'b1;
    rdata  = rdat;
    rresp  = resp;
    @(negedge clock);
    rvalid = 1'b0;
    rresp  = 2'b00;
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] rdat;
    logic [1:0]  resp;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_tab [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ld_tab[0] = '{MEM_LB,  32'h8000_0003, 32'h80AA_BBCC, 2'b00, 32'hFFFF_FF80};
    ld_tab[1] = '{MEM_LBU, 32'h8000_0003, 32'h80AA_BBCC, 2'b00, 32'h0000_0080};
    ld_tab[2] = '{MEM_LH,  32'h8000_0002, 32'h80AA_BBCC, 2'b00, 32'hFFFF_80AA};
    ld_tab[3] = '{MEM_LHU, 32'h8000_0000, 32'h1234_F00D, 2'b00, 32'h0000_F00D};
    ld_tab[4] = '{MEM_LW,  32'h8000_0004, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF};
    ld_tab[5] = '{MEM_LW,  32'h8000_0008, 32'hDEAD_BEEF, 2'b10, 32'hDEAD_BEEF};

    reset = 1'b0;
    req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 12'h0, 1'b0);
    req_off();
    is_req_ready_from_wbu = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    repeat (2) @(negedge clock);
    check("rst_valid_wbu", 32'(is_req_valid_to_wbu), 32'd0);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_result", result_out_lsu, 32'h0);
    check("rst_wstrb", 32'(wstrb), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_bready", 32'(bready), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Passthrough, back to back, 1-cycle latency.
    is_req_ready_from_wbu = 1'b1;
    req(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 1'b0, 12'h0, 1'b0);
    @(negedge clock);
    check("pt_valid", 32'(is_req_valid_to_wbu), 32'd1);
    check("pt_result", result_out_lsu, 32'h1234_5678);
    check("pt_rd", 32'(rd_out_lsu), 32'd5);
    check("pt_regw", 32'(reg_write_out_lsu), 32'd1);
    check("pt_no_ar", 32'(arvalid), 32'd0);
    check("pt_no_aw", 32'(awvalid), 32'd0);
    check("pt_exu_ready", 32'(is_req_ready_to_exu), 32'd1);
    req(1'b0, 1'b0, 3'b000, 32'hCAFE_0001, 32'h0, 5'd7, 1'b0, 1'b1, 12'h305, 1'b1);
    @(negedge clock);
    req_off();
    check("pt2_result", result_out_lsu, 32'hCAFE_0001);
    check("pt2_rd", 32'(rd_out_lsu), 32'd7);
    check("pt2_csrw", 32'(csr_write_out_lsu), 32'd1);
    check("pt2_csra", 32'(csr_addr_out_lsu), 32'h305);
    check("pt2_ebreak", 32'(ebreak_out_lsu), 32'd1);
    check("pt2_regw", 32'(reg_write_out_lsu), 32'd0);
    @(negedge clock);
    check("pt_drain", 32'(is_req_valid_to_wbu), 32'd0);

    // Loads with extraction and a bus error.
    for (int i = 0; i < 6; i++) begin
      logic exp_fault;
      exp_fault = ld_tab[i].resp != 2'b00;
      do_load(ld_tab[i].op, ld_tab[i].addr, ld_tab[i].rdat, ld_tab[i].resp, 5'(i + 1));
      check($sformatf("ld%0d_valid", i), 32'(is_req_valid_to_wbu), 32'd1);
      check($sformatf("ld%0d_fault", i), 32'(access_fault_out_lsu), 32'(exp_fault));
      check($sformatf("ld%0d_regw", i), 32'(reg_write_out_lsu), 32'(!exp_fault));
      check($sformatf("ld%0d_rd", i), 32'(rd_out_lsu), 32'(i + 1));
      if (!exp_fault) check($sformatf("ld%0d_data", i), result_out_lsu, ld_tab[i].exp);
    end
    @(negedge clock);

    // Misaligned word load and store never touch the bus.
    req(1'b1, 1'b0, MEM_LW, 32'h8000_0002, 32'h0, 5'd3, 1'b1, 1'b0, 12'h0, 1'b0);
    @(negedge clock);
    req_off();
    check("mis_lw_valid", 32'(is_req_valid_to_wbu), 32'd1);
    check("mis_lw_fault", 32'(access_fault_out_lsu), 32'd1);
    check("mis_lw_regw", 32'(reg_write_out_lsu), 32'd0);
    check("mis_lw_ar", 32'(arvalid), 32'd0);
    @(negedge clock);
    check("mis_lw_ar2", 32'(arvalid), 32'd0);
    req(1'b0, 1'b1, MEM_SW, 32'h8000_0001, 32'h11, 5'd0, 1'b0, 1'b0, 12'h0, 1'b0);
    @(negedge clock);
    req_off();
    check("mis_sw_fault", 32'(access_fault_out_lsu), 32'd1);
    check("mis_sw_aw", 32'(awvalid), 32'd0);
    check("mis_sw_w", 32'(wvalid), 32'd0);
    @(negedge clock);

    // SH with AW accepted two cycles before W.
    req(1'b0, 1'b1, MEM_SH, 32'h8000_0002, 32'h0000_BEEF, 5'd0, 1'b0, 1'b0, 12'h0, 1'b0);
    @(negedge clock);
    req_off();
    check("sh_awvalid", 32'(awvalid), 32'd1);
    check("sh_wvalid", 32'(wvalid), 32'd1);
    check("sh_awaddr", awaddr, 32'h8000_0002);
    check("sh_wdata", wdata, 32'hBEEF_0000);
    check("sh_wstrb", 32'(wstrb), 32'hC);
    check("sh_awsize", 32'(awsize), 32'd1);
    check("sh_exu_busy", 32'(is_req_ready_to_exu), 32'd0);
    awready = 1'b1;
    @(negedge clock);
    awready = 1'b0;
    check("sh_aw_drop", 32'(awvalid), 32'd0);
    check("sh_w_hold", 32'(wvalid), 32'd1);
    check("sh_no_bready", 32'(bready), 32'd0);
    @(negedge clock);
    check("sh_w_hold2", 32'(wvalid), 32'd1);
    check("sh_wdata_stable", wdata, 32'hBEEF_0000);
    wready = 1'b1;
    @(negedge clock);
    wready = 1'b0;
    check("sh_w_drop", 32'(wvalid), 32'd0);
    check("sh_bready", 32'(bready), 32'd1);
    check("sh_not_early", 32'(is_req_valid_to_wbu), 32'd0);
    bvalid = 1'b1;
    @(negedge clock);
    bvalid = 1'b0;
    check("sh_done", 32'(is_req_valid_to_wbu), 32'd1);
    check("sh_fault", 32'(access_fault_out_lsu), 32'd0);
    check("sh_bready_low", 32'(bready), 32'd0);

    // SB with an error response forcing csr_write low.
    req(1'b0, 1'b1, MEM_SB, 32'h8000_0001, 32'h0000_00A5, 5'd0, 1'b0, 1'b1, 12'h341, 1'b0);
    @(negedge clock);
    req_off();
    check("sb_wdata", wdata, 32'h0000_A500);
    check("sb_wstrb", 32'(wstrb), 32'h2);
    awready = 1'b1; wready = 1'b1;
    @(negedge clock);
    awready = 1'b0; wready = 1'b0;
    check("sb_bready", 32'(bready), 32'd1);
    bvalid = 1'b1; bresp = 2'b11;
    @(negedge clock);
    bvalid = 1'b0; bresp = 2'b00;
    check("sb_valid", 32'(is_req_valid_to_wbu), 32'd1);
    check("sb_fault", 32'(access_fault_out_lsu), 32'd1);
    check("sb_csrw", 32'(csr_write_out_lsu), 32'd0);
    @(negedge clock);

    // WBU backpressure holds the load result and blocks EXU.
    is_req_ready_from_wbu = 1'b0;
    do_load(MEM_LW, 32'h8000_0010, 32'h0BAD_F00D, 2'b00, 5'd9);
    check("bp_valid", 32'(is_req_valid_to_wbu), 32'd1);
    check("bp_result", result_out_lsu, 32'h0BAD_F00D);
    req(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd2, 1'b1, 1'b0, 12'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp%0d_exu_ready", k), 32'(is_req_ready_to_exu), 32'd0);
      check($sformatf("bp%0d_hold", k), result_out_lsu, 32'h0BAD_F00D);
      @(negedge clock);
    end
    is_req_ready_from_wbu = 1'b1;
    #1;
    check("bp_exu_ready", 32'(is_req_ready_to_exu), 32'd1);
    @(negedge clock);
    req_off();
    check("bp_next_result", result_out_lsu, 32'h0000_0055);
    check("bp_next_valid", 32'(is_req_valid_to_wbu), 32'd1);
    is_req_ready_from_wbu = 1'b0;
    @(negedge clock);
    check("bp_held", 32'(is_req_valid_to_wbu), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_async_valid", 32'(is_req_valid_to_wbu), 32'd0);
    check("rst_async_result", result_out_lsu, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Reset while in WR_REQ.
    is_req_ready_from_wbu = 1'b1;
    req(1'b0, 1'b1, MEM_SW, 32'h8000_0010, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 12'h0, 1'b0);
    @(negedge clock);
    req_off();
    check("wr_awvalid", 32'(awvalid), 32'd1);
    check("wr_wstrb", 32'(wstrb), 32'hF);
    #2 reset = 1'b0;
    #1;
    check("wr_rst_aw", 32'(awvalid), 32'd0);
    check("wr_rst_w", 32'(wvalid), 32'd0);
    check("wr_rst_valid", 32'(is_req_valid_to_wbu), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("wr_post_aw", 32'(awvalid), 32'd0);
    check("wr_post_idle", 32'(is_req_ready_to_exu), 32'd1);
    check("wr_post_bready", 32'(bready), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
